// File: rtl/pit_channel.sv
// pit_channel: one counter channel of an 8254-style programmable interval timer.
// Supports effective modes 0 (interrupt on terminal count), 2 (rate generator)
// and 3 (square wave), binary counting only, with count latch and byte-wise
// read/write sequencing controlled by the RW field of the control word.
module pit_channel (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iClkEnPit,
  input  logic       iGate,
  input  logic       iWrCtrl,
  input  logic       iWrData,
  input  logic       iRd,
  input  logic [7:0] iData,
  output logic [7:0] oData,
  output logic       oOut
);

  // Effective counting behaviour after folding the eight M encodings.
  typedef enum logic [1:0] {EM0 = 2'd0, EM2 = 2'd2, EM3 = 2'd3} emode_t;

  // Counter life cycle: idle (no valid count), armed (count complete, waiting
  // for the load tick), running.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_RUN = 2'd2} cnt_st_t;

  function automatic emode_t decode_mode(input logic [2:0] m);
    case (m[1:0])
      2'b10:   return EM2;
      2'b11:   return EM3;
      default: return EM0;
    endcase
  endfunction

  // Programming state
  logic [1:0]  rw_q;
  logic [2:0]  m_q;
  logic [15:0] n_q;
  logic [7:0]  lsb_q;
  logic        wr_msb_q;
  logic        prog_q;

  // Read state
  logic        rd_msb_q;
  logic        latch_vld_q;
  logic [15:0] latch_q;

  // Counter state
  cnt_st_t     st_q;
  logic [15:0] ce_q;
  logic        out_q;
  logic        gate_q;
  logic        trig_q;

  // Decoded strobes and derived values
  emode_t      emode;
  emode_t      ctrl_emode;
  logic        ctrl_prog;
  logic        ctrl_latch;
  logic        byte_wr;
  logic        byte_rd;
  logic        tick_en;
  logic        first_byte;
  logic        complete;
  logic [15:0] new_n;
  logic [15:0] m2_len;
  logic [15:0] hi_len;
  logic [15:0] lo_len;
  logic [15:0] load_val;
  logic        rd_sel_msb;
  logic        rd_final;
  logic [15:0] rd_src;
  logic        ctrl_unused;

  // BCD and the channel-select bits are not used by this channel.
  assign ctrl_unused = ^{iData[7:6], iData[0]};

  assign emode      = decode_mode(m_q);
  assign ctrl_emode = decode_mode(iData[3:1]);
  assign ctrl_prog  = iWrCtrl && (iData[5:4] != 2'b00);
  assign ctrl_latch = iWrCtrl && (iData[5:4] == 2'b00);
  // A control write swallows any byte access presented in the same cycle.
  assign byte_wr    = iWrData && !iWrCtrl;
  assign byte_rd    = iRd && !iWrCtrl;
  // Reprogramming stops the counter, so a coincident tick is dropped.
  assign tick_en    = iClkEnPit && !ctrl_prog;

  // Count write sequencing
  always_comb begin
    first_byte = (rw_q != 2'b11) || !wr_msb_q;
    complete   = (rw_q != 2'b11) || wr_msb_q;
    case (rw_q)
      2'b01:   new_n = {8'h00, iData};
      2'b10:   new_n = {iData, 8'h00};
      default: new_n = {iData, lsb_q};
    endcase
  end

  // Reload values per mode; N=0 stands for 65536, which the 16-bit CE
  // already represents as 0 for modes 0 and 2.
  always_comb begin
    m2_len = (n_q == 16'd1) ? 16'd2 : n_q;
    if (n_q == 16'd0) begin
      hi_len = 16'h8000;
      lo_len = 16'h8000;
    end else begin
      hi_len = (n_q >> 1) + {15'd0, n_q[0]};
      lo_len = n_q >> 1;
    end
    case (emode)
      EM2:     load_val = m2_len;
      EM3:     load_val = hi_len;
      default: load_val = n_q;
    endcase
  end

  // Read byte selection: latched value wins over the live counter
  always_comb begin
    rd_sel_msb = (rw_q == 2'b10) || ((rw_q == 2'b11) && rd_msb_q);
    rd_final   = (rw_q != 2'b11) || rd_msb_q;
    rd_src     = latch_vld_q ? latch_q : ce_q;
    oData      = 8'h00;
    if (iRd) oData = rd_sel_msb ? rd_src[15:8] : rd_src[7:0];
  end

  assign oOut = out_q;

  // Control word and count register programming
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rw_q     <= 2'b11;
      m_q      <= 3'd0;
      n_q      <= 16'd0;
      lsb_q    <= 8'h00;
      wr_msb_q <= 1'b0;
      prog_q   <= 1'b0;
    end else if (ctrl_prog) begin
      rw_q     <= iData[5:4];
      m_q      <= iData[3:1];
      wr_msb_q <= 1'b0;
      prog_q   <= 1'b1;
    end else if (byte_wr) begin
      if ((rw_q == 2'b11) && !wr_msb_q) begin
        // Hold the LSB aside so a reload never sees a half-written N.
        lsb_q    <= iData;
        wr_msb_q <= 1'b1;
      end else begin
        n_q      <= new_n;
        wr_msb_q <= 1'b0;
      end
    end
  end

  // Read pointer and count latch
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rd_msb_q    <= 1'b0;
      latch_vld_q <= 1'b0;
      latch_q     <= 16'd0;
    end else if (ctrl_prog) begin
      rd_msb_q    <= 1'b0;
      latch_vld_q <= 1'b0;
    end else if (ctrl_latch) begin
      // A repeated latch command is ignored until the latch has been read out.
      if (!latch_vld_q) begin
        latch_vld_q <= 1'b1;
        latch_q     <= ce_q;
      end
    end else if (byte_rd) begin
      if (rw_q == 2'b11) rd_msb_q <= !rd_msb_q;
      if (rd_final) latch_vld_q <= 1'b0;
    end
  end

  // Gate rising-edge capture: modes 2/3 restart from N on the next tick
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      gate_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      gate_q <= iGate;
      if (ctrl_prog)
        trig_q <= 1'b0;
      else if (tick_en && ((st_q == ST_ARMED) || ((st_q == ST_RUN) && iGate)))
        trig_q <= 1'b0;
      else if (iGate && !gate_q && (st_q == ST_RUN) && (emode != EM0))
        trig_q <= 1'b1;
    end
  end

  // Counter FSM: load, decrement, reload and OUT generation
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      st_q  <= ST_IDLE;
      ce_q  <= 16'd0;
      out_q <= 1'b0;
    end else if (ctrl_prog) begin
      st_q  <= ST_IDLE;
      out_q <= (ctrl_emode != EM0);
    end else begin
      if (tick_en) begin
        case (st_q)
          ST_ARMED: begin
            // Load tick: copy N, no decrement.
            ce_q <= load_val;
            st_q <= ST_RUN;
            if (emode != EM0) out_q <= 1'b1;
          end
          ST_RUN: begin
            if (iGate) begin
              if (trig_q && (emode != EM0)) begin
                ce_q  <= load_val;
                out_q <= 1'b1;
              end else begin
                case (emode)
                  EM2: begin
                    if (ce_q == 16'd1) begin
                      ce_q  <= load_val;
                      out_q <= 1'b1;
                    end else begin
                      ce_q <= ce_q - 16'd1;
                      if (ce_q == 16'd2) out_q <= 1'b0;
                    end
                  end
                  EM3: begin
                    // CE counts ticks left in the current half period.
                    if (ce_q == 16'd1) begin
                      if (out_q && (lo_len != 16'd0)) begin
                        out_q <= 1'b0;
                        ce_q  <= lo_len;
                      end else begin
                        out_q <= 1'b1;
                        ce_q  <= hi_len;
                      end
                    end else begin
                      ce_q <= ce_q - 16'd1;
                    end
                  end
                  default: begin
                    ce_q <= ce_q - 16'd1;
                    if (ce_q == 16'd1) out_q <= 1'b1;
                  end
                endcase
              end
            end
          end
          default: ;
        endcase
      end
      if (!iGate && (emode != EM0)) out_q <= 1'b1;
      if (byte_wr) begin
        // Mode 0 restarts on the first byte of a new count.
        if (first_byte && (emode == EM0)) begin
          out_q <= 1'b0;
          st_q  <= ST_IDLE;
        end
        // Modes 2/3 already running pick the new N up at their next reload.
        if (complete && prog_q &&
            ((st_q != ST_RUN) || (first_byte && (emode == EM0))))
          st_q <= ST_ARMED;
      end
    end
  end

endmodule

// File: tb/tb_pit_channel.sv
// tb_pit_channel: randomized self-checking bench for pit_channel. Expected OUT
// and count values come from closed-form per-mode formulas of the tick index k
// counted from the load tick.
module tb_pit_channel;

  logic       iClk = 1'b0;
  logic       iRstN, iClkEnPit, iGate, iWrCtrl, iWrData, iRd;
  logic [7:0] iData;
  logic [7:0] oData;
  logic       oOut;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] rdv;

  always #5 iClk = ~iClk;

  pit_channel dut (
    .iClk(iClk), .iRstN(iRstN), .iClkEnPit(iClkEnPit), .iGate(iGate),
    .iWrCtrl(iWrCtrl), .iWrData(iWrData), .iRd(iRd), .iData(iData),
    .oData(oData), .oOut(oOut)
  );

  // ---------------- reference formulas ----------------
  function automatic int eff_n(input int n);
    return (n == 0) ? 65536 : n;
  endfunction
  function automatic logic m0_out(input int n, input int k);
    return k >= eff_n(n);
  endfunction
  function automatic logic [15:0] m0_ce(input int n, input int k);
    return 16'(n - k);
  endfunction
  function automatic int m2_np(input int n);
    return (n == 1) ? 2 : eff_n(n);
  endfunction
  function automatic logic m2_out(input int n, input int k);
    return (k % m2_np(n)) != (m2_np(n) - 1);
  endfunction
  function automatic logic [15:0] m2_ce(input int n, input int k);
    return 16'(m2_np(n) - (k % m2_np(n)));
  endfunction
  function automatic logic m3_out(input int n, input int k);
    return (k % eff_n(n)) < ((eff_n(n) + 1) / 2);
  endfunction

  // ---------------- stimulus primitives ----------------
  // Called at a falling edge; spans one rising edge; returns at the next falling edge.
  task automatic step(input bit tk, input bit wc, input bit wd, input bit rd, input logic [7:0] d);
    iClkEnPit = tk; iWrCtrl = wc; iWrData = wd; iRd = rd; iData = d;
    #1 rdv = oData;
    @(negedge iClk);
    iClkEnPit = 0; iWrCtrl = 0; iWrData = 0; iRd = 0; iData = 8'h00;
  endtask
  task automatic ctrl(input logic [7:0] w); step(0, 1, 0, 0, w); endtask
  task automatic wbyte(input logic [7:0] b); step(0, 0, 1, 0, b); endtask
  task automatic read_word(output logic [15:0] v);
    step(0, 0, 0, 1, 8'h00); v[7:0]  = rdv;
    step(0, 0, 0, 1, 8'h00); v[15:8] = rdv;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] v;
    iRstN = 0; iGate = 1; iClkEnPit = 0; iWrCtrl = 0; iWrData = 0; iRd = 0; iData = 0;
    repeat (2) @(negedge iClk);
    checks++; if (oOut !== 1'b0) begin fails++; $display("FAIL rst_out got %b exp 0", oOut); end
    iRd = 1; #1;
    checks++; if (oData !== 8'h00) begin fails++; $display("FAIL rst_data got %h exp 00", oData); end
    iRd = 0;
    @(negedge iClk);
    iRstN = 1;
    // Count without a control word must not start the counter.
    wbyte(8'h03); wbyte(8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 8'h00);
      checks++; if (oOut !== 1'b0) begin fails++; $display("FAIL rst_idle_out i=%0d got %b exp 0", i, oOut); end
    end
    read_word(v);
    checks++; if (v !== 16'h0000) begin fails++; $display("FAIL rst_idle_ce got %h exp 0000", v); end
  endtask

  task automatic test_mode2();
    int n, k; bit loaded, tk; logic exp; logic [15:0] v; int nl[3]; int kw, b;
    nl[0] = 4; nl[1] = 1; nl[2] = $urandom_range(2, 12);
    for (int j = 0; j < 3; j++) begin
      n = nl[j];
      ctrl(8'h34);
      checks++; if (oOut !== 1'b1) begin fails++; $display("FAIL m2_ctrl_out n=%0d got %b exp 1", n, oOut); end
      wbyte(8'(n)); wbyte(8'(n >> 8));
      loaded = 0; k = 0;
      for (int i = 0; i < 40; i++) begin
        tk = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        step(tk, 0, 0, 0, 8'h00);
        if (tk) begin if (loaded) k++; else begin loaded = 1; k = 0; end end
        exp = m2_out(n, k);
        checks++; if (oOut !== exp) begin fails++; $display("FAIL m2_out n=%0d k=%0d got %b exp %b", n, k, oOut, exp); end
      end
      read_word(v);
      checks++; if (v !== m2_ce(n, k)) begin fails++; $display("FAIL m2_ce n=%0d k=%0d got %h exp %h", n, k, v, m2_ce(n, k)); end
    end
    // Gate behaviour with N=4
    n = 4; ctrl(8'h34); wbyte(8'h04); wbyte(8'h00);
    k = 0; step(1, 0, 0, 0, 8'h00);
    repeat (6) begin step(1, 0, 0, 0, 8'h00); k++; end
    iGate = 0; step(0, 0, 0, 0, 8'h00);
    checks++; if (oOut !== 1'b1) begin fails++; $display("FAIL m2_gate_out got %b exp 1", oOut); end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 8'h00);
      checks++; if (oOut !== 1'b1) begin fails++; $display("FAIL m2_gatelow_out i=%0d got %b exp 1", i, oOut); end
    end
    read_word(v);
    checks++; if (v !== m2_ce(n, k)) begin fails++; $display("FAIL m2_gate_frozen got %h exp %h", v, m2_ce(n, k)); end
    iGate = 1; step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 8'h00);
      k = (i == 0) ? 0 : k + 1;
      exp = m2_out(n, k);
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m2_retrig k=%0d got %b exp %b", k, oOut, exp); end
    end
    // New N applies at the next reload
    wbyte(8'h06); wbyte(8'h00);
    kw = k; b = (kw / 4 + 1) * 4;
    for (int i = 0; i < 30; i++) begin
      tk = 1'($urandom_range(0, 1));
      step(tk, 0, 0, 0, 8'h00);
      if (tk) k++;
      exp = (k < b) ? m2_out(4, k) : m2_out(6, k - b);
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m2_newn k=%0d b=%0d got %b exp %b", k, b, oOut, exp); end
    end
  endtask

  task automatic test_mode0();
    int n, k; bit loaded, tk, g; logic exp; logic [15:0] v;
    ctrl(8'h30);
    checks++; if (oOut !== 1'b0) begin fails++; $display("FAIL m0_ctrl_out got %b exp 0", oOut); end
    wbyte(8'h05); wbyte(8'h00);
    for (int t = 1; t <= 12; t++) begin
      step(1, 0, 0, 0, 8'h00);
      exp = m0_out(5, t - 1);
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m0_out t=%0d got %b exp %b", t, oOut, exp); end
    end
    read_word(v);
    checks++; if (v !== m0_ce(5, 11)) begin fails++; $display("FAIL m0_wrap_ce got %h exp %h", v, m0_ce(5, 11)); end
    // First byte of a new count forces OUT low and halts counting
    wbyte(8'h0A);
    checks++; if (oOut !== 1'b0) begin fails++; $display("FAIL m0_first_byte got %b exp 0", oOut); end
    repeat (4) step(1, 0, 0, 0, 8'h00);
    wbyte(8'h00);
    n = 10; loaded = 0; k = 0;
    for (int i = 0; i < 80; i++) begin
      tk = 1'($urandom_range(0, 1)); g = ($urandom_range(0, 3) != 0);
      iGate = g;
      step(tk, 0, 0, 0, 8'h00);
      if (tk) begin if (loaded) begin if (g) k++; end else begin loaded = 1; k = 0; end end
      exp = loaded && m0_out(n, k);
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m0_rand k=%0d got %b exp %b", k, oOut, exp); end
    end
    iGate = 1; step(1, 0, 0, 0, 8'h00);
    if (loaded) k++; else begin loaded = 1; k = 0; end
    read_word(v);
    checks++; if (v !== m0_ce(n, k)) begin fails++; $display("FAIL m0_rand_ce k=%0d got %h exp %h", k, v, m0_ce(n, k)); end
  endtask

  task automatic test_mode3();
    int n, k, kw, b; bit loaded, tk; logic exp;
    ctrl(8'h36);
    checks++; if (oOut !== 1'b1) begin fails++; $display("FAIL m3_ctrl_out got %b exp 1", oOut); end
    wbyte(8'h05); wbyte(8'h00);
    loaded = 0; k = 0;
    for (int i = 0; i < 30; i++) begin
      tk = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(tk, 0, 0, 0, 8'h00);
      if (tk) begin if (loaded) k++; else begin loaded = 1; k = 0; end end
      exp = m3_out(5, k);
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m3_n5 k=%0d got %b exp %b", k, oOut, exp); end
    end
    wbyte(8'h06); wbyte(8'h00);
    kw = k; b = kw + 1;
    while ((b % 5 != 0) && (b % 5 != 3)) b++;
    for (int i = 0; i < 40; i++) begin
      tk = 1'($urandom_range(0, 1));
      step(tk, 0, 0, 0, 8'h00);
      if (tk) k++;
      if (k < b) exp = m3_out(5, k);
      else if (b % 5 == 3) exp = ((k - b + 3) % 6) < 3;
      else exp = ((k - b) % 6) < 3;
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m3_n6 k=%0d b=%0d got %b exp %b", k, b, oOut, exp); end
    end
    n = $urandom_range(2, 15);
    ctrl(8'h36); wbyte(8'(n)); wbyte(8'h00);
    loaded = 0; k = 0;
    for (int i = 0; i < 60; i++) begin
      tk = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(tk, 0, 0, 0, 8'h00);
      if (tk) begin if (loaded) k++; else begin loaded = 1; k = 0; end end
      exp = m3_out(n, k);
      checks++; if (oOut !== exp) begin fails++; $display("FAIL m3_rand n=%0d k=%0d got %b exp %b", n, k, oOut, exp); end
    end
  endtask

  task automatic test_latch();
    int k; logic [15:0] lv, live;
    ctrl(8'h34); wbyte(8'h34); wbyte(8'h12);
    step(1, 0, 0, 0, 8'h00); k = 0;
    repeat (50) begin step(1, 0, 0, 0, 8'h00); k++; end
    ctrl(8'h04);
    lv = m2_ce(16'h1234, k);
    repeat (30) begin step(1, 0, 0, 0, 8'h00); k++; end
    ctrl(8'h04);
    repeat (70) begin step(1, 0, 0, 0, 8'h00); k++; end
    live = m2_ce(16'h1234, k);
    step(0, 0, 0, 1, 8'h00);
    checks++; if (rdv !== lv[7:0]) begin fails++; $display("FAIL latch_lsb got %h exp %h", rdv, lv[7:0]); end
    step(0, 0, 0, 1, 8'h00);
    checks++; if (rdv !== lv[15:8]) begin fails++; $display("FAIL latch_msb got %h exp %h", rdv, lv[15:8]); end
    step(0, 0, 0, 1, 8'h00);
    checks++; if (rdv !== live[7:0]) begin fails++; $display("FAIL latch_release got %h exp %h", rdv, live[7:0]); end
    step(0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_edge();
    logic [15:0] v;
    // LSB-only and MSB-only read/write ordering
    ctrl(8'h14); wbyte(8'h09); step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 8'h00);
      checks++; if (rdv !== 8'h09) begin fails++; $display("FAIL lsb_only i=%0d got %h exp 09", i, rdv); end
    end
    ctrl(8'h24); wbyte(8'h01); step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 8'h00);
      checks++; if (rdv !== 8'h01) begin fails++; $display("FAIL msb_only i=%0d got %h exp 01", i, rdv); end
    end
    // Control write coincident with a data write
    step(0, 1, 1, 0, 8'h34);
    wbyte(8'h07); wbyte(8'h00); step(1, 0, 0, 0, 8'h00);
    read_word(v);
    checks++; if (v !== m2_ce(7, 0)) begin fails++; $display("FAIL ctrl_wr_collide got %h exp %h", v, m2_ce(7, 0)); end
    // Control write coincident with a read after a half-finished read pair
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 1, 8'h34);
    wbyte(8'h03); wbyte(8'h02); step(1, 0, 0, 0, 8'h00);
    read_word(v);
    checks++; if (v !== m2_ce(16'h0203, 0)) begin fails++; $display("FAIL ctrl_rd_collide got %h exp %h", v, m2_ce(16'h0203, 0)); end
    // Asynchronous reset mid-count
    repeat (3) step(1, 0, 0, 0, 8'h00);
    #2 iRstN = 0;
    #1;
    checks++; if (oOut !== 1'b0) begin fails++; $display("FAIL rst_async got %b exp 0", oOut); end
    @(negedge iClk);
    iRstN = 1;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 8'h00);
      checks++; if (oOut !== 1'b0) begin fails++; $display("FAIL rst_mid_out i=%0d got %b exp 0", i, oOut); end
    end
    read_word(v);
    checks++; if (v !== 16'h0000) begin fails++; $display("FAIL rst_mid_ce got %h exp 0000", v); end
  endtask

  task automatic test_n0_mode2();
    int k, first_low; logic [15:0] v; logic exp;
    ctrl(8'h34); wbyte(8'h00); wbyte(8'h00);
    step(1, 0, 0, 0, 8'h00); k = 0;
    first_low = -1;
    for (int i = 1; i <= 65537; i++) begin
      step(1, 0, 0, 0, 8'h00); k = i;
      if (!oOut && first_low < 0) first_low = k;
    end
    checks++; if (first_low !== 65535) begin fails++; $display("FAIL n0_first_low got %0d exp 65535", first_low); end
    exp = m2_out(0, k);
    checks++; if (oOut !== exp) begin fails++; $display("FAIL n0_after_reload got %b exp %b", oOut, exp); end
    read_word(v);
    checks++; if (v !== m2_ce(0, k)) begin fails++; $display("FAIL n0_ce got %h exp %h", v, m2_ce(0, k)); end
  endtask

  initial begin
    test_reset();
    test_mode2();
    test_mode0();
    test_mode3();
    test_latch();
    test_edge();
    test_n0_mode2();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pit_channel.md
PIT_CHANNEL -- requirements
Module: pit_channel

Interface
REQ-001 Parameters: none.
REQ-002 iClk  in  1  system clock, 10 MHz; all state changes on its rising edge.
REQ-003 iRstN  in  1  asynchronous active-low reset.
REQ-004 iClkEnPit  in  1  one-iClk-wide count tick at 1.193182 MHz, generated by the PIT clock enable block.
REQ-005 iGate  in  1  gate input; high enables counting.
REQ-006 iWrCtrl  in  1  one-cycle strobe: iData is a control word addressed to this channel; SC bits 7:6 are decoded upstream.
REQ-007 iWrData  in  1  one-cycle strobe: iData is a count byte.
REQ-008 iRd  in  1  one-cycle strobe: read of a count byte; advances the read byte pointer.
REQ-009 iData  in  8  write data.
REQ-010 oData  out  8  read data, combinational from current read state, valid while iRd is high.
REQ-011 oOut  out  1  channel OUT, registered.

Function
REQ-012 Control word format: bits 5:4 = RW, bits 3:1 = mode M, bit 0 = BCD; BCD is ignored and counting is always binary.
REQ-013 RW encoding: 00 = latch command; 01 = LSB only; 10 = MSB only; 11 = LSB then MSB.
REQ-014 RW=00 copies the 16-bit count into the output latch without changing mode, RW, count or OUT; a second latch command issued while the latch is unread is ignored.
REQ-015 RW!=00 latches RW and M, clears both byte pointers, clears the latch, stops counting until a new count is loaded, and sets oOut (0 for mode 0, 1 otherwise) on the next edge.
REQ-016 Effective mode: M=0,1,4,5 act as mode 0; M=2,6 act as mode 2; M=3,7 act as mode 3.
REQ-017 Count writes:
- LSB-only writes {8'h00, byte}.
- MSB-only writes {byte, 8'h00}.
- LSB/MSB: first byte to LSB, second byte to MSB; the count register N is complete after the second byte.
REQ-018 N=0 means 65536; mode 2 with N=1 behaves as N=2.
REQ-019 In mode 0, writing the first byte of a count drives oOut low on the next edge and halts counting until N is complete.
REQ-020 Load: N is copied to counter CE on the first iClkEnPit strictly after the cycle that completes N; a tick coinciding with the completing write does not load. The load tick does not decrement.
REQ-021 Mode 0:
- CE decrements by 1 on each iClkEnPit with iGate=1.
- oOut rises on the tick where CE becomes 0, so oOut rises N+1 ticks after the write, and stays high.
- CE wraps from 0 to FFFF and keeps counting; oOut is unaffected by the wrap.
REQ-022 Mode 2:
- oOut is high except for one tick period where CE=1.
- On the next tick CE reloads N and oOut returns high.
- The period is N ticks.
- A new N takes effect at the next reload, not immediately.
REQ-023 Mode 3:
- Square wave with a period of N ticks.
- Even N: high N/2 ticks, then low N/2 ticks.
- Odd N: high (N+1)/2 ticks, then low (N-1)/2 ticks.
- A new N takes effect at the next half-period boundary.
REQ-024 Gate:
- iGate=0 suspends decrement in all modes.
- In modes 2 and 3, iGate=0 forces oOut high on the next edge.
- An iGate rising edge in modes 2 and 3 reloads CE from N on the next tick.
REQ-025 Reads:
- oData returns the latch when latched, else live CE.
- Byte order follows RW: LSB-only always LSB; MSB-only always MSB; LSB/MSB alternates LSB, MSB.
- The latch releases after the final byte of the RW sequence has been read.
REQ-026 Simultaneous iRd and tick: oData reflects CE before the decrement.
REQ-027 Simultaneous control write and iRd or iWrData: the control write takes priority and the byte access is discarded.

Reset
REQ-028 iRstN low immediately sets:
- oOut=0, oData=0x00
- mode 0, RW=11
- N=0, CE=0
- both byte pointers cleared, latch cleared
- counter idle with no count loaded
REQ-029 After reset the channel does not count until a control word and a complete count are written; ticks are ignored.
REQ-030 Reset asserted mid-count aborts all activity; after release, REQ-029 applies.

Verification
REQ-031 Mode 0: ctrl 0x30, write 0x05, 0x00; tick continuously -> oOut low, rises on the 6th tick after the MSB write, stays high; CE then reads FFFF and keeps decrementing.
REQ-032 Mode 2: ctrl 0x34, N=4 -> after load, oOut pattern per tick H,H,H,L repeating; period 4 ticks; gate low for 10 ticks -> oOut high, CE frozen.
REQ-033 Mode 3: ctrl 0x36, N=5 then N=6 -> for N=5, oOut high 3 ticks, low 2; for N=6, high 3, low 3, applied from the next half-period boundary.
REQ-034 Latch: mode 2, N=0x1234; latch command 0x04 while counting; wait 100 ticks; two reads -> return the latched LSB then MSB; the third read returns live CE LSB.
REQ-035 Edge cases:
- N=0 in mode 2 -> period 65536 ticks.
- Control write coincident with iWrData -> data byte discarded, both pointers clear.
- iRstN pulse mid-count -> oOut=0 with no counting until reprogrammed.
